unified_mem_arb: RTL and testbench
==================================

// Module: unified_mem_arb
// PURPOSE
//  Parametrised single-ported, byte-addressed unified memory with two request ports:
//  instruction fetch (word loads only) and data (RV32I loads/stores by funct3).
//  A built-in arbiter grants one access per cycle. Reads are registered: 1-cycle latency.
//  Misaligned or illegal-funct3 accesses return an error and never modify memory.
// PARAMETERS
//  ADDR_W     8    byte-address width; memory holds 2**ADDR_W bytes
//  INIT_FILE  ""   hex image loaded with $readmemh at time 0 ("" = no preload)
//  ARB_MODE   1    0 = data port always wins; 1 = round-robin when both request
// PORTS
//  clk        in   1       clock, all state updates on rising edge
//  rst        in   1       synchronous reset, active-high
//  if_req     in   1       fetch request (level)
//  if_addr    in   ADDR_W  fetch byte address
//  if_gnt     out  1       fetch accepted this cycle (combinational)
//  if_valid   out  1       fetch response valid (1-cycle pulse)
//  if_rdata   out  32      fetched word
//  if_err     out  1       fetch misaligned (qualifies if_valid)
//  d_req      in   1       data request (level)
//  d_we       in   1       1 = store, 0 = load
//  d_funct3   in   3       access size/sign, RV32I encoding
//  d_addr     in   ADDR_W  data byte address
//  d_wdata    in   32      store data (low bytes used for SB/SH)
//  d_gnt      out  1       data accepted this cycle (combinational)
//  d_valid    out  1       data response valid (1-cycle pulse, loads and stores)
//  d_rdata    out  32      load result, sign/zero extended; 0 for stores/errors
//  d_err      out  1       misaligned or illegal funct3 (qualifies d_valid)
// BEHAVIOUR
//  - Reset: all outputs 0, arbiter state = last_grant DATA; memory contents NOT cleared.
//    While rst=1: if_gnt=d_gnt=0, no writes, no responses; accesses in flight are dropped.
//  - Accept: request accepted on the rising edge where req & gnt; requester may change
//    req/addr/data in the next cycle. Back-to-back accepts on one port are allowed.
//  - Arbitration: one grant per cycle. Single requester always granted.
//    Both requesting: ARB_MODE=0 -> data; ARB_MODE=1 -> port NOT granted last (1-bit state
//    updated only on an actual grant).
//  - Latency: accept in cycle N -> valid/rdata/err registered, visible in cycle N+1, held
//    for exactly one cycle; outputs return to 0 afterwards unless a new response follows.
//  - Little-endian: byte at addr is bits [7:0].
//  - Loads (d_we=0): 000 LB sign-ext, 001 LH sign-ext (bit 15), 010 LW, 100 LBU, 101 LHU.
//  - Stores (d_we=1): 000 SB, 001 SH, 010 SW; write committed on the accept edge.
//  - Alignment: halfword needs addr[0]=0, word needs addr[1:0]=0; byte always aligned.
//    Fetch is always a word. Violation, or funct3 not listed for the op, -> err=1,
//    rdata=0, no memory update; response still follows in N+1.
//  - Aligned accesses never cross the top of memory, so no wrap-around occurs.
//  - Same-address store then load accepted in consecutive cycles: load returns new data.
//  - Uninitialised bytes read as X in simulation; the bench preloads before use.
// TESTING
//  - Reset: rst=1 for 3 cycles with if_req=d_req=1 -> no gnt, no valid; outputs 0.
//  - SW 0xDEADBEEF @0x10, then LB/LBU/LH/LHU @0x13/0x13/0x12/0x12
//    -> 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000DEAD, each 1 cycle after gnt.
//  - SB 0x5A @0x11 over 0xDEADBEEF word, LW @0x10 -> 0xDEAD5AEF.
//  - Misaligned: LH @0x21, SW @0x22, fetch @0x06, d_funct3=011 load -> err=1, rdata=0,
//    LW @0x20 afterwards shows word unchanged.
//  - Contention, ARB_MODE=1, both req held 6 cycles -> grants alternate D,I,D,I,D,I;
//    ARB_MODE=0 -> 6 data grants, 0 fetch grants.
//  - Reset mid-op: accept LW in cycle N, rst=1 in N+1 -> d_valid stays 0.

Source files
------------

// File: rtl/unified_mem_arb.sv
// unified_mem_arb
//   Single-ported, byte-addressed unified memory shared by an instruction-fetch
//   port and an RV32I data port. A built-in arbiter grants at most one access
//   per cycle. Responses are registered and appear one cycle after acceptance.
//   Misaligned or illegal-funct3 accesses respond with err=1 and rdata=0, and
//   never modify memory.
// Ports
//   clk, rst                 clock; synchronous active-high reset
//   if_req/if_addr           fetch request (word loads only)
//   if_gnt                   fetch accepted this cycle (combinational)
//   if_valid/if_rdata/if_err fetch response, one-cycle pulse
//   d_req/d_we/d_funct3      data request, store enable, RV32I size/sign
//   d_addr/d_wdata           data byte address, store data
//   d_gnt                    data accepted this cycle (combinational)
//   d_valid/d_rdata/d_err    data response, one-cycle pulse
module unified_mem_arb #(
    parameter int unsigned ADDR_W    = 8,
    parameter              INIT_FILE = "",
    parameter int unsigned ARB_MODE  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [31:0]       d_rdata,
    output logic              d_err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {
        GNT_DATA  = 1'b0,
        GNT_FETCH = 1'b1
    } grant_e;

    grant_e r_last, w_last_nxt;

    logic [7:0] r_mem [DEPTH];

    logic              w_if_gnt, w_d_gnt;
    logic [ADDR_W-1:0] w_d_a1, w_d_a2, w_d_a3;
    logic [ADDR_W-1:0] w_if_a1, w_if_a2, w_if_a3;
    logic [7:0]        w_db0, w_db1, w_db2, w_db3;
    logic [31:0]       w_d_load, w_if_word;
    logic              w_d_legal, w_d_misal, w_d_err, w_if_err;

    logic        r_if_valid, r_if_err, r_d_valid, r_d_err;
    logic [31:0] r_if_rdata, r_d_rdata;

    // Arbiter state: remembers which port won the last actual grant
    always_ff @(posedge clk) begin
        if (rst) r_last <= GNT_DATA;
        else     r_last <= w_last_nxt;
    end

    always_comb begin
        w_if_gnt   = 1'b0;
        w_d_gnt    = 1'b0;
        w_last_nxt = r_last;
        if (!rst) begin
            if (d_req && if_req) begin
                if (ARB_MODE == 0 || r_last == GNT_FETCH) w_d_gnt  = 1'b1;
                else                                      w_if_gnt = 1'b1;
            end else begin
                w_d_gnt  = d_req;
                w_if_gnt = if_req;
            end
            if (w_d_gnt)       w_last_nxt = GNT_DATA;
            else if (w_if_gnt) w_last_nxt = GNT_FETCH;
        end
    end

    assign w_d_a1  = d_addr + ADDR_W'(1);
    assign w_d_a2  = d_addr + ADDR_W'(2);
    assign w_d_a3  = d_addr + ADDR_W'(3);
    assign w_if_a1 = if_addr + ADDR_W'(1);
    assign w_if_a2 = if_addr + ADDR_W'(2);
    assign w_if_a3 = if_addr + ADDR_W'(3);

    assign w_db0 = r_mem[d_addr];
    assign w_db1 = r_mem[w_d_a1];
    assign w_db2 = r_mem[w_d_a2];
    assign w_db3 = r_mem[w_d_a3];

    assign w_if_word = {r_mem[w_if_a3], r_mem[w_if_a2], r_mem[w_if_a1], r_mem[if_addr]};
    assign w_if_err  = (if_addr[1:0] != 2'b00);

    always_comb begin
        w_d_legal = 1'b0;
        w_d_load  = '0;
        case (d_funct3)
            3'b000: begin
                w_d_legal = 1'b1;
                w_d_load  = {{24{w_db0[7]}}, w_db0};
            end
            3'b001: begin
                w_d_legal = 1'b1;
                w_d_load  = {{16{w_db1[7]}}, w_db1, w_db0};
            end
            3'b010: begin
                w_d_legal = 1'b1;
                w_d_load  = {w_db3, w_db2, w_db1, w_db0};
            end
            3'b100: begin
                w_d_legal = !d_we;
                w_d_load  = {24'h0, w_db0};
            end
            3'b101: begin
                w_d_legal = !d_we;
                w_d_load  = {16'h0, w_db1, w_db0};
            end
            default: begin
                w_d_legal = 1'b0;
                w_d_load  = '0;
            end
        endcase
        // funct3[1:0] encodes the access size for every legal encoding
        w_d_misal = ((d_funct3[1:0] == 2'b01) && d_addr[0]) ||
                    ((d_funct3[1:0] == 2'b10) && (d_addr[1:0] != 2'b00));
        w_d_err   = !w_d_legal || w_d_misal;
    end

    // Memory is never reset; stores commit on the accept edge
    always_ff @(posedge clk) begin
        if (w_d_gnt && d_we && !w_d_err) begin
            r_mem[d_addr] <= d_wdata[7:0];
            if (d_funct3[1:0] != 2'b00) r_mem[w_d_a1] <= d_wdata[15:8];
            if (d_funct3[1:0] == 2'b10) begin
                r_mem[w_d_a2] <= d_wdata[23:16];
                r_mem[w_d_a3] <= d_wdata[31:24];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_valid <= 1'b0;
            r_if_err   <= 1'b0;
            r_if_rdata <= '0;
            r_d_valid  <= 1'b0;
            r_d_err    <= 1'b0;
            r_d_rdata  <= '0;
        end else begin
            r_if_valid <= w_if_gnt;
            r_if_err   <= w_if_gnt && w_if_err;
            r_if_rdata <= (w_if_gnt && !w_if_err) ? w_if_word : '0;
            r_d_valid  <= w_d_gnt;
            r_d_err    <= w_d_gnt && w_d_err;
            r_d_rdata  <= (w_d_gnt && !d_we && !w_d_err) ? w_d_load : '0;
        end
    end

    // Responses are masked while rst is high so an access accepted just
    // before reset never surfaces
    assign if_gnt   = w_if_gnt;
    assign d_gnt    = w_d_gnt;
    assign if_valid = r_if_valid && !rst;
    assign if_err   = r_if_err && !rst;
    assign if_rdata = rst ? '0 : r_if_rdata;
    assign d_valid  = r_d_valid && !rst;
    assign d_err    = r_d_err && !rst;
    assign d_rdata  = rst ? '0 : r_d_rdata;

endmodule

// File: tb/tb_unified_mem_arb.sv
// Testbench for unified_mem_arb: directed vectors, scoreboard queues per port,
// monitors compare each response against the queued expectation and cycle.
module tb_unified_mem_arb;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [7:0]  if_addr, d_addr;
    logic [2:0]  d_funct3;
    logic [31:0] d_wdata;
    logic        if_gnt, if_valid, if_err, d_gnt, d_valid, d_err;
    logic [31:0] if_rdata, d_rdata;

    logic        f_if_req, f_d_req;
    logic        f_if_gnt, f_if_valid, f_if_err, f_d_gnt, f_d_valid, f_d_err;
    logic [31:0] f_if_rdata, f_d_rdata;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q_d[$];
    exp_t q_if[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    unified_mem_arb #(.ADDR_W(8), .ARB_MODE(1)) u_rr (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_valid(if_valid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_valid(d_valid),
        .d_rdata(d_rdata), .d_err(d_err)
    );

    unified_mem_arb #(.ADDR_W(8), .ARB_MODE(0)) u_fix (
        .clk(clk), .rst(rst),
        .if_req(f_if_req), .if_addr(if_addr), .if_gnt(f_if_gnt),
        .if_valid(f_if_valid), .if_rdata(f_if_rdata), .if_err(f_if_err),
        .d_req(f_d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(f_d_gnt), .d_valid(f_d_valid),
        .d_rdata(f_d_rdata), .d_err(f_d_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        exp_t e;
        if (d_valid) begin
            n_checks++;
            if (q_d.size() == 0) begin
                n_fail++;
                $display("FAIL d_unexpected: d_valid=1 rdata=%h err=%b, none expected (cycle %0d)",
                         d_rdata, d_err, cyc);
            end else begin
                e = q_d.pop_front();
                if (d_rdata !== e.rdata || d_err !== e.err || cyc != e.cyc + 1) begin
                    n_fail++;
                    $display("FAIL d_resp: got rdata=%h err=%b cycle=%0d expected rdata=%h err=%b cycle=%0d",
                             d_rdata, d_err, cyc, e.rdata, e.err, e.cyc + 1);
                end
            end
        end
        if (if_valid) begin
            n_checks++;
            if (q_if.size() == 0) begin
                n_fail++;
                $display("FAIL if_unexpected: if_valid=1 rdata=%h err=%b, none expected (cycle %0d)",
                         if_rdata, if_err, cyc);
            end else begin
                e = q_if.pop_front();
                if (if_rdata !== e.rdata || if_err !== e.err || cyc != e.cyc + 1) begin
                    n_fail++;
                    $display("FAIL if_resp: got rdata=%h err=%b cycle=%0d expected rdata=%h err=%b cycle=%0d",
                             if_rdata, if_err, cyc, e.rdata, e.err, e.cyc + 1);
                end
            end
        end
    end

    task automatic d_op(input logic we, input logic [2:0] f3, input logic [7:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee);
        bit done = 1'b0;
        d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (d_gnt) begin
                q_d.push_back('{rdata: er, err: ee, cyc: cyc});
                done = 1'b1;
            end
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL d_gnt_timeout: got no grant expected grant within 20 cycles");
        end
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic if_op(input logic [7:0] a, input logic [31:0] er, input logic ee);
        bit done = 1'b0;
        if_req = 1'b1; if_addr = a;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (if_gnt) begin
                q_if.push_back('{rdata: er, err: ee, cyc: cyc});
                done = 1'b1;
            end
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL if_gnt_timeout: got no grant expected grant within 20 cycles");
        end
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    initial begin
        int fd_cnt = 0;
        int fi_cnt = 0;
        logic exp_d;

        rst = 1'b1; if_req = 1'b1; d_req = 1'b1; f_if_req = 1'b1; f_d_req = 1'b1;
        if_addr = 8'h00; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 8'h00; d_wdata = '0;

        // Reset with both ports requesting
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_gnts", {30'h0, if_gnt, d_gnt}, 32'h0);
            check("rst_valids_errs", {28'h0, if_valid, d_valid, if_err, d_err}, 32'h0);
            check("rst_if_rdata", if_rdata, 32'h0);
            check("rst_d_rdata", d_rdata, 32'h0);
            check("rst_fix_gnts", {30'h0, f_if_gnt, f_d_gnt}, 32'h0);
        end
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0; f_if_req = 1'b0; f_d_req = 1'b0; rst = 1'b0;

        // Word store then sub-word loads with sign/zero extension
        d_op(1'b1, 3'b010, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        d_op(1'b0, 3'b000, 8'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
        d_op(1'b0, 3'b100, 8'h13, 32'h0, 32'h000000DE, 1'b0);
        d_op(1'b0, 3'b001, 8'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
        d_op(1'b0, 3'b101, 8'h12, 32'h0, 32'h0000DEAD, 1'b0);

        // Byte store into an existing word
        d_op(1'b1, 3'b000, 8'h11, 32'h1234565A, 32'h0, 1'b0);
        d_op(1'b0, 3'b010, 8'h10, 32'h0, 32'hDEAD5AEF, 1'b0);

        // Misaligned and illegal accesses leave memory untouched
        d_op(1'b1, 3'b010, 8'h20, 32'hCAFEF00D, 32'h0, 1'b0);
        d_op(1'b0, 3'b001, 8'h21, 32'h0, 32'h0, 1'b1);
        d_op(1'b1, 3'b010, 8'h22, 32'h11111111, 32'h0, 1'b1);
        d_op(1'b1, 3'b001, 8'h21, 32'h22222222, 32'h0, 1'b1);
        if_op(8'h06, 32'h0, 1'b1);
        d_op(1'b0, 3'b011, 8'h20, 32'h0, 32'h0, 1'b1);
        d_op(1'b1, 3'b100, 8'h20, 32'h33333333, 32'h0, 1'b1);
        d_op(1'b0, 3'b010, 8'h20, 32'h0, 32'hCAFEF00D, 1'b0);

        // Store then same-address load in consecutive cycles
        d_op(1'b1, 3'b001, 8'h30, 32'h0000BEEF, 32'h0, 1'b0);
        d_op(1'b0, 3'b101, 8'h30, 32'h0, 32'h0000BEEF, 1'b0);
        d_op(1'b0, 3'b001, 8'h30, 32'h0, 32'hFFFFBEEF, 1'b0);

        // Aligned fetch; also leaves the round-robin pointer at FETCH
        if_op(8'h10, 32'hDEAD5AEF, 1'b0);

        // Contention: both ports held for 6 cycles on both arbiter modes
        if_addr = 8'h10; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 8'h10;
        if_req = 1'b1; d_req = 1'b1; f_if_req = 1'b1; f_d_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp_d = ((i % 2) == 0);
            check("rr_d_gnt", {31'h0, d_gnt}, {31'h0, exp_d});
            check("rr_if_gnt", {31'h0, if_gnt}, {31'h0, !exp_d});
            if (d_gnt)  q_d.push_back('{rdata: 32'hDEAD5AEF, err: 1'b0, cyc: cyc});
            if (if_gnt) q_if.push_back('{rdata: 32'hDEAD5AEF, err: 1'b0, cyc: cyc});
            if (f_d_gnt)  fd_cnt++;
            if (f_if_gnt) fi_cnt++;
        end
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0; f_if_req = 1'b0; f_d_req = 1'b0;
        check("fix_d_grants", fd_cnt, 32'd6);
        check("fix_if_grants", fi_cnt, 32'd0);

        // Reset right after an accepted load drops its response
        repeat (2) @(posedge clk);
        #1;
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 8'h10;
        @(negedge clk);
        check("midrst_accept", {31'h0, d_gnt}, 32'h1);
        @(posedge clk); #1;
        d_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("midrst_d_valid", {31'h0, d_valid}, 32'h0);
        check("midrst_d_rdata", d_rdata, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("postrst_d_valid", {31'h0, d_valid}, 32'h0);
        @(posedge clk); #1;

        // Memory survives reset
        d_op(1'b0, 3'b010, 8'h10, 32'h0, 32'hDEAD5AEF, 1'b0);

        repeat (3) @(negedge clk);
        check("q_d_drained", q_d.size(), 32'd0);
        check("q_if_drained", q_if.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
